scope_renderer: RTL and testbench

Beam-path generator for the oscilloscope pong display. Each frame it snapshots the game state (ball position, paddle centre, score) and traces it on the XY deflection DACs: ball dot, then paddle segment, then an optional score bar. A beam blank (Z) output suppresses retrace. It sits between the game controller outputs and the DAC/Z-axis drivers, and is the consumer of `x_b`, `y_b`, `y_p_mid` and `score`.

---
 rtl/scope_renderer.sv | 174 +++++++++++++++++
 tb/tb_scope_renderer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/scope_renderer.sv
// XY beam-path generator for the scope pong display: ball dot, paddle segment and optional score bar.
// Optional score bar is compiled in when the SCORE_BAR_EN macro is defined.
module scope_renderer #(
  parameter int unsigned X_MAX           = 255,
  parameter int unsigned Y_MAX           = 220,
  parameter int unsigned PLATE_HALFWIDTH = 15,
  parameter int unsigned BALL_DWELL      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x_b,
  input  logic [7:0] y_b,
  input  logic [7:0] y_p_mid,
  input  logic [7:0] score,
  output logic [7:0] dac_x,
  output logic [7:0] dac_y,
  output logic       blank,
  output logic       frame_start
);

  localparam logic [7:0] XM      = 8'(X_MAX);
  localparam logic [7:0] YM      = 8'(Y_MAX);
  localparam logic [7:0] HW      = 8'(PLATE_HALFWIDTH);
  localparam logic [7:0] YM_HW   = 8'(Y_MAX - PLATE_HALFWIDTH);
  localparam logic [7:0] DW_LAST = 8'(BALL_DWELL - 1);

  typedef enum logic [2:0] {
    SNAP,
    BALL,
    MOVE_P,
    PADDLE,
    MOVE_S,
    SCORE
  } state_t;

  state_t     state, state_d;
  logic [7:0] cnt;
  logic [7:0] x_lat, y_lat;
  logic [7:0] y_min_r, y_max_r;
  logic [7:0] y_min_c, y_max_c;
  logic       paddle_done;

  logic [7:0] dac_x_d, dac_y_d;
  logic       blank_d, frame_start_d;

`ifdef SCORE_BAR_EN
  logic [7:0] score_lat;
  logic [7:0] bar_last;
  // Bar length saturates at 128 samples so x = 2k never exceeds 254.
  assign bar_last = (score_lat >= 8'd128) ? 8'd127 : score_lat - 8'd1;
`else
  logic unused_score;
  assign unused_score = ^score;
`endif

  assign y_min_c = (y_p_mid >= HW)    ? y_p_mid - HW : '0;
  assign y_max_c = (y_p_mid <= YM_HW) ? y_p_mid + HW : YM;
  // >= rather than == keeps an out-of-range paddle centre from wrapping the counter.
  assign paddle_done = (cnt >= y_max_r);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SNAP;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      SNAP:   state_d = BALL;
      BALL:   if (cnt == DW_LAST) state_d = MOVE_P;
      MOVE_P: state_d = PADDLE;
      PADDLE: begin
        if (paddle_done) begin
`ifdef SCORE_BAR_EN
          state_d = (score_lat != '0) ? MOVE_S : SNAP;
`else
          state_d = SNAP;
`endif
        end
      end
`ifdef SCORE_BAR_EN
      MOVE_S: state_d = SCORE;
      SCORE:  if (cnt == bar_last) state_d = SNAP;
`endif
      default: state_d = SNAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      x_lat   <= '0;
      y_lat   <= '0;
      y_min_r <= '0;
      y_max_r <= '0;
`ifdef SCORE_BAR_EN
      score_lat <= '0;
`endif
    end else begin
      case (state)
        SNAP: begin
          cnt     <= '0;
          x_lat   <= x_b;
          y_lat   <= y_b;
          y_min_r <= y_min_c;
          y_max_r <= y_max_c;
`ifdef SCORE_BAR_EN
          score_lat <= score;
`endif
        end
        BALL:   cnt <= (cnt == DW_LAST) ? '0 : cnt + 8'd1;
        // The paddle pass reuses cnt as the current y sample.
        MOVE_P: cnt <= y_min_r;
        PADDLE: cnt <= paddle_done ? '0 : cnt + 8'd1;
`ifdef SCORE_BAR_EN
        MOVE_S: cnt <= '0;
        SCORE:  cnt <= (cnt == bar_last) ? '0 : cnt + 8'd1;
`endif
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    dac_x_d       = dac_x;
    dac_y_d       = dac_y;
    blank_d       = 1'b1;
    frame_start_d = 1'b0;
    case (state)
      BALL: begin
        dac_x_d       = x_lat;
        dac_y_d       = y_lat;
        blank_d       = 1'b0;
        frame_start_d = (cnt == '0);
      end
      MOVE_P: begin
        dac_x_d = XM;
        dac_y_d = y_min_r;
      end
      PADDLE: begin
        dac_x_d = XM;
        dac_y_d = cnt;
        blank_d = 1'b0;
      end
`ifdef SCORE_BAR_EN
      MOVE_S: begin
        dac_x_d = '0;
        dac_y_d = YM;
      end
      SCORE: begin
        dac_x_d = {cnt[6:0], 1'b0};
        dac_y_d = YM;
        blank_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dac_x       <= '0;
      dac_y       <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      dac_x       <= dac_x_d;
      dac_y       <= dac_y_d;
      blank       <= blank_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_scope_renderer.sv
// Directed bench for scope_renderer: checks every beam sample of each frame against hand-derived values.
module tb_scope_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] x_b = 8'd100;
  logic [7:0] y_b = 8'd50;
  logic [7:0] y_p_mid = 8'd110;
  logic [7:0] score = 8'd0;
  logic [7:0] dac_x, dac_y;
  logic       blank, frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_x = 8'd0;
  logic [7:0] last_y = 8'd0;

  scope_renderer #(
    .X_MAX(255),
    .Y_MAX(220),
    .PLATE_HALFWIDTH(15),
    .BALL_DWELL(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .x_b(x_b),
    .y_b(y_b),
    .y_p_mid(y_p_mid),
    .score(score),
    .dac_x(dac_x),
    .dac_y(dac_y),
    .blank(blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                     input logic eb, input logic ef);
    n_checks++;
    assert ({dac_x, dac_y, blank, frame_start} === {ex, ey, eb, ef})
    else begin
      n_fail++;
      $error("FAIL %s: got x=%0d y=%0d blank=%0b fs=%0b, expected x=%0d y=%0d blank=%0b fs=%0b",
             tag, dac_x, dac_y, blank, frame_start, ex, ey, eb, ef);
    end
  endtask

  // Called at a negedge whose next posedge is the SNAP edge.
  task automatic run_frame(input logic [7:0] ex, input logic [7:0] ey,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] sc, input int poke_idx,
                           input logic [7:0] poke_x, input int abort_idx);
    int idx;
    @(negedge clk);
    chk("snap", last_x, last_y, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("ball%0d", i), ex, ey, 1'b0, i == 0);
    end
    @(negedge clk);
    chk("move_p", 8'd255, lo, 1'b1, 1'b0);
    idx = 0;
    for (int y = lo; y <= hi; y++) begin
      @(negedge clk);
      chk($sformatf("paddle y%0d", y), 8'd255, 8'(y), 1'b0, 1'b0);
      if (idx == poke_idx) x_b = poke_x;
      if (idx == abort_idx) begin
        reset = 1'b0;
        #1;
        chk("async_reset", 8'd0, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("held_reset", 8'd0, 8'd0, 1'b1, 1'b0);
        reset = 1'b1;
        last_x = 8'd0;
        last_y = 8'd0;
        return;
      end
      idx++;
    end
    last_x = 8'd255;
    last_y = hi;
`ifdef SCORE_BAR_EN
    if (sc != 8'd0) begin
      int n;
      n = (sc > 8'd128) ? 128 : int'(sc);
      @(negedge clk);
      chk("move_s", 8'd0, 8'd220, 1'b1, 1'b0);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        chk($sformatf("bar%0d", k), 8'(2 * k), 8'd220, 1'b0, 1'b0);
      end
      last_x = 8'(2 * (n - 1));
      last_y = 8'd220;
    end
`else
    if (sc != 8'd0) last_x = 8'd255;
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", 8'd0, 8'd0, 1'b1, 1'b0);
    reset = 1'b1;

    run_frame(8'd100, 8'd50, 8'd95, 8'd125, 8'd0, -1, 8'd0, -1);
    run_frame(8'd100, 8'd50, 8'd95, 8'd125, 8'd0, -1, 8'd0, -1);

    score = 8'd3;
    run_frame(8'd100, 8'd50, 8'd95, 8'd125, 8'd3, -1, 8'd0, -1);
    score = 8'd0;

    y_p_mid = 8'd5;
    run_frame(8'd100, 8'd50, 8'd0, 8'd20, 8'd0, -1, 8'd0, -1);
    y_p_mid = 8'd215;
    run_frame(8'd100, 8'd50, 8'd200, 8'd220, 8'd0, -1, 8'd0, -1);

    y_p_mid = 8'd110;
    run_frame(8'd100, 8'd50, 8'd95, 8'd125, 8'd0, 10, 8'd30, -1);
    x_b = 8'd30;
    y_b = 8'd70;
    run_frame(8'd30, 8'd70, 8'd95, 8'd125, 8'd0, -1, 8'd0, 5);
    run_frame(8'd30, 8'd70, 8'd95, 8'd125, 8'd0, -1, 8'd0, -1);

    score = 8'd200;
    run_frame(8'd30, 8'd70, 8'd95, 8'd125, 8'd200, -1, 8'd0, -1);
    score = 8'd0;
    run_frame(8'd30, 8'd70, 8'd95, 8'd125, 8'd0, -1, 8'd0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
